// File: rtl/res_writeback.sv
// rtl/res_writeback.sv - dp result row buffer and lane serialiser into the result SRAM (option: RES_WB_RELU_EN)
module res_writeback #(
  parameter int RES_W = 16,
  parameter int LANES = 8,
  parameter int DEPTH = 4704,
  parameter int AW    = 13
) (
  input  logic                   ck,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_valid,
  input  logic [RES_W*LANES-1:0] i_data,
  output logic                   o_wr_en,
  output logic [AW-1:0]          o_wr_addr,
  output logic [RES_W-1:0]       o_wr_data,
  input  logic                   i_wr_ready,
  output logic                   o_full,
  output logic                   o_ovf,
  output logic                   o_done
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state, state_nx;
  logic [RES_W*LANES-1:0] row_mem [2];
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             count, count_nx;
  logic [LW-1:0]          lane_ptr;
  logic [AW-1:0]          addr;
  logic                   done, ovf;
  logic                   beat, last_lane, pop, push, done_set;
  logic [RES_W-1:0]       head_lane [LANES];
  logic [RES_W-1:0]       raw, lane_out;

  // Beat/pop/push decisions and next count/state, all from registered state
  always_comb begin
    beat      = (state == DRAIN) && i_wr_ready;
    last_lane = (lane_ptr == LW'(LANES - 1));
    pop       = beat && last_lane;
    done_set  = beat && (addr == AW'(DEPTH - 1));
    // A retiring row frees its slot in the same cycle, so a full buffer can still accept
    push      = i_valid && !done && ((count != 2'd2) || pop);
    count_nx  = count;
    if (push && !pop)
      count_nx = count + 2'd1;
    else if (pop && !push)
      count_nx = count - 2'd1;
    // Rows still buffered after the last layer beat are discarded
    if (done_set)
      count_nx = 2'd0;
    // Looking at the next count lets a fresh row start draining on the very next cycle
    state_nx = ((count_nx != 2'd0) && !done && !done_set) ? DRAIN : IDLE;
  end

  // Control state: FSM, FIFO pointers, lane/address counters, sticky flags
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      lane_ptr <= '0;
      addr     <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else if (i_clr) begin
      state    <= IDLE;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      lane_ptr <= '0;
      addr     <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (beat) begin
        lane_ptr <= last_lane ? '0 : lane_ptr + LW'(1);
        if (!done_set)
          addr <= addr + AW'(1);
      end
      if (done_set)
        done <= 1'b1;
      if (i_valid && !push)
        ovf <= 1'b1;
    end
  end

  // Row storage carries no reset; occupancy is tracked by count alone
  always_ff @(posedge ck) begin
    if (push && !i_clr)
      row_mem[wr_ptr] <= i_data;
  end

  // Slice the head row into lanes, lane 0 in the most significant slice
  always_comb begin
    for (int k = 0; k < LANES; k++)
      head_lane[k] = row_mem[rd_ptr][RES_W*(LANES-k)-1 -: RES_W];
  end

  // Output mux with optional clamp of negative lanes to zero
  always_comb begin
    raw = head_lane[lane_ptr];
`ifdef RES_WB_RELU_EN
    lane_out = raw[RES_W-1] ? '0 : raw;
`else
    lane_out = raw;
`endif
  end

  assign o_wr_en   = (state == DRAIN);
  assign o_wr_addr = addr;
  assign o_wr_data = (state == DRAIN) ? lane_out : '0;
  assign o_full    = (count == 2'd2);
  assign o_ovf     = ovf;
  assign o_done    = done;

endmodule

// File: tb/tb_res_writeback.sv
// tb/tb_res_writeback.sv - directed self-checking bench for res_writeback
module tb_res_writeback;

  localparam int RES_W = 16;
  localparam int LANES = 8;
  localparam int DEPTH = 4704;
  localparam int AW    = 13;

  logic                   ck = 1'b0;
  logic                   rst_n, i_clr, i_valid, i_wr_ready;
  logic [RES_W*LANES-1:0] i_data;
  logic                   o_wr_en, o_full, o_ovf, o_done;
  logic [AW-1:0]          o_wr_addr;
  logic [RES_W-1:0]       o_wr_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] beats[$];

  res_writeback #(.RES_W(RES_W), .LANES(LANES), .DEPTH(DEPTH), .AW(AW)) dut (
    .ck(ck), .rst_n(rst_n), .i_clr(i_clr), .i_valid(i_valid), .i_data(i_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_wr_ready(i_wr_ready), .o_full(o_full), .o_ovf(o_ovf), .o_done(o_done)
  );

  always #5 ck = ~ck;

  // Record every accepted beat as {addr, data}, sampled mid-cycle
  always @(negedge ck)
    if (rst_n && o_wr_en && i_wr_ready)
      beats.push_back({3'b000, o_wr_addr, o_wr_data});

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [RES_W*LANES-1:0] mk_row(input logic [15:0] base);
    logic [RES_W*LANES-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      r[RES_W*(LANES-k)-1 -: RES_W] = base + 16'(k);
    return r;
  endfunction

  task automatic check_beats(input string tag, input int n, input logic [15:0] d0);
    logic [31:0] got;
    chk({tag, "_count"}, beats.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < beats.size()) ? beats[i] : 32'hxxxx_xxxx;
      chk({tag, "_beat"}, got, {16'(i), d0 + 16'(i)});
    end
  endtask

  initial begin
    int bad;
    logic [15:0] exp_neg;
    rst_n = 1'b0; i_clr = 1'b0; i_valid = 1'b0; i_wr_ready = 1'b1; i_data = '0;

    // Reset and idle
    repeat (3) @(posedge ck);
    #1;
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_addr", o_wr_addr, 0);
    chk("rst_data", o_wr_data, 0);
    chk("rst_full", o_full, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_done", o_done, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_wr_en", o_wr_en, 0);
    chk("idle_beats", beats.size(), 0);

    // Single row, first beat in the cycle after i_valid
    i_data = mk_row(16'h0001); i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("row_first_en", o_wr_en, 1);
    chk("row_first_addr", o_wr_addr, 0);
    chk("row_first_data", o_wr_data, 16'h0001);
    repeat (10) step();
    chk("row_end_en", o_wr_en, 0);
    check_beats("row", 8, 16'h0001);

    // Backpressure at lane 3
    i_clr = 1'b1; step(); i_clr = 1'b0;
    chk("clr_addr", o_wr_addr, 0);
    beats.delete();
    i_valid = 1'b1; step(); i_valid = 1'b0;
    repeat (3) step();
    i_wr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_en", o_wr_en, 1);
      chk("bp_addr", o_wr_addr, 3);
      chk("bp_data", o_wr_data, 16'h0004);
      step();
    end
    i_wr_ready = 1'b1;
    repeat (10) step();
    check_beats("bp", 8, 16'h0001);

    // Overflow: three rows back to back while memory stalls
    i_clr = 1'b1; step(); i_clr = 1'b0;
    beats.delete();
    i_wr_ready = 1'b0;
    i_data = mk_row(16'h0001); i_valid = 1'b1; step();
    chk("ovf_full1", o_full, 0);
    i_data = mk_row(16'h0009); step();
    chk("ovf_full2", o_full, 1);
    chk("ovf_ovf2", o_ovf, 0);
    i_data = mk_row(16'h0011); step();
    chk("ovf_ovf3", o_ovf, 1);
    i_valid = 1'b0; i_wr_ready = 1'b1;
    repeat (20) step();
    check_beats("ovf", 16, 16'h0001);

    // Push coinciding with last-lane pop while full
    i_clr = 1'b1; step(); i_clr = 1'b0;
    chk("clr_ovf", o_ovf, 0);
    beats.delete();
    i_wr_ready = 1'b0;
    i_data = mk_row(16'h0001); i_valid = 1'b1; step();
    i_data = mk_row(16'h0009); step();
    i_valid = 1'b0; i_wr_ready = 1'b1;
    repeat (7) step();
    i_data = mk_row(16'h0011); i_valid = 1'b1; step(); i_valid = 1'b0;
    chk("pp_full", o_full, 1);
    chk("pp_ovf", o_ovf, 0);
    repeat (20) step();
    check_beats("pp", 24, 16'h0001);

    // Completion: 588 rows, data equals address
    i_clr = 1'b1; step(); i_clr = 1'b0;
    beats.delete();
    for (int r = 0; r < DEPTH / LANES; r++) begin
      i_data = mk_row(16'(r * LANES)); i_valid = 1'b1; step();
      i_valid = 1'b0;
      repeat (7) step();
    end
    chk("cmp_pre_done", o_done, 0);
    chk("cmp_last_addr", o_wr_addr, DEPTH - 1);
    chk("cmp_last_en", o_wr_en, 1);
    step();
    chk("cmp_done", o_done, 1);
    chk("cmp_en_off", o_wr_en, 0);
    chk("cmp_addr_hold", o_wr_addr, DEPTH - 1);
    chk("cmp_ovf_clean", o_ovf, 0);
    chk("cmp_count", beats.size(), DEPTH);
    bad = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] !== {16'(i), 16'(i)}) bad++;
    chk("cmp_stream_bad", bad, 0);
    i_valid = 1'b1; step(); i_valid = 1'b0;
    chk("cmp_late_ovf", o_ovf, 1);
    repeat (3) step();
    chk("cmp_no_write", beats.size(), DEPTH);
    chk("cmp_late_en", o_wr_en, 0);

    // Negative and positive lanes through the output mux
    i_clr = 1'b1; step(); i_clr = 1'b0;
`ifdef RES_WB_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'hFFF0;
`endif
    i_data = {16'hFFF0, 16'h7FFF, 96'h0}; i_valid = 1'b1; step(); i_valid = 1'b0;
    chk("relu_neg", o_wr_data, exp_neg);
    step();
    chk("relu_pos", o_wr_data, 16'h7FFF);

    // Reset mid-burst withdraws the beat without a clock edge
    step();
    chk("mid_en_before", o_wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_en_async", o_wr_en, 0);
    chk("mid_addr_async", o_wr_addr, 0);
    step();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
